dmem_arbiter: RTL

- Shares the single-port data memory between two requesters: port 0 is the CPU load/store path and port 1 is the program/data loader or debug path.
- Performs at most one memory access per cycle.
- Uses round-robin arbitration with a burst limit, so a streaming requester cannot starve the other.
- Sits between the CPU datapath's memory address/write-data/Mem_Write signals and the Data_Mem instance.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arb_pick.sv | 37 +++
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the two-port data-memory arbiter.
// Port 0 is the CPU load/store path, port 1 the loader/debug path.
package dmem_arb_pkg;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_AUX = 1'b1
   } port_id_t;

   localparam int ADDR_W_DEF    = 32;
   localparam int DATA_W_DEF    = 32;
   localparam int MAX_BURST_DEF = 4;

   // Wide enough for the largest legal burst limit (15).
   localparam int BURST_W = 4;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection: round-robin with a burst limit on the
// current owner while the other port is also requesting.
module dmem_arb_pick
   import dmem_arb_pkg::*;
#(
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic               req0,
   input  logic               req1,
   input  port_id_t           owner,
   input  logic [BURST_W-1:0] burst_cnt,
   output logic               gnt0,
   output logic               gnt1
);

   localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

   logic keep_owner;

   always_comb begin
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      keep_owner = (burst_cnt < MAX_B);
      if (req0 && req1) begin
         // Owner keeps the port until its burst allowance runs out.
         if ((owner == PORT_CPU) == keep_owner) begin
            gnt0 = 1'b1;
         end else begin
            gnt1 = 1'b1;
         end
      end else begin
         gnt0 = req0;
         gnt1 = req1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port, 1-cycle-latency data memory.
// Define DMEM_ARB_PERF_EN to build the saturating contention counter.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [15:0]       perf_conflict_cnt
);

   localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

   port_id_t           owner_q, owner_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic               rd_pend_q, rd_pend_d;
   port_id_t           rd_tag_q, rd_tag_d;
   logic [DATA_W-1:0]  rdata0_q, rdata0_d;
   logic [DATA_W-1:0]  rdata1_q, rdata1_d;
   logic               pick0, pick1;
   port_id_t           win;

   dmem_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
      .req0      (req0),
      .req1      (req1),
      .owner     (owner_q),
      .burst_cnt (burst_q),
      .gnt0      (pick0),
      .gnt1      (pick1)
   );

   // Reset blocks any access from reaching the memory.
   assign gnt0 = pick0 & ~rst;
   assign gnt1 = pick1 & ~rst;
   assign win  = gnt1 ? PORT_AUX : PORT_CPU;

   // Read data is live from memory in the rvalid cycle, then held.
   assign rvalid0 = rd_pend_q && (rd_tag_q == PORT_CPU);
   assign rvalid1 = rd_pend_q && (rd_tag_q == PORT_AUX);
   assign rdata0  = rvalid0 ? mem_rd_data : rdata0_q;
   assign rdata1  = rvalid1 ? mem_rd_data : rdata1_q;

   always_comb begin
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wr_data = '0;
      if (gnt0) begin
         mem_we      = we0;
         mem_addr    = addr0;
         mem_wr_data = wdata0;
      end else if (gnt1) begin
         mem_we      = we1;
         mem_addr    = addr1;
         mem_wr_data = wdata1;
      end
   end

   always_comb begin
      owner_d   = owner_q;
      burst_d   = '0;
      rd_pend_d = (gnt0 && !we0) || (gnt1 && !we1);
      rd_tag_d  = win;
      rdata0_d  = rdata0;
      rdata1_d  = rdata1;
      if (gnt0 || gnt1) begin
         if (win == owner_q) begin
            burst_d = (burst_q >= MAX_B) ? MAX_B : burst_q + 1'b1;
         end else begin
            owner_d = win;
            burst_d = BURST_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q   <= PORT_CPU;
         burst_q   <= '0;
         rd_pend_q <= 1'b0;
         rd_tag_q  <= PORT_CPU;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         owner_q   <= owner_d;
         burst_q   <= burst_d;
         rd_pend_q <= rd_pend_d;
         rd_tag_q  <= rd_tag_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

`ifdef DMEM_ARB_PERF_EN
   logic [15:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (req0 && req1 && (perf_q != 16'hFFFF)) begin
         perf_d = perf_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_conflict_cnt = perf_q;
`else
   assign perf_conflict_cnt = 16'h0000;
`endif

endmodule
